// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared definitions for the register-file write-back stage: row/address widths,
// source indices, the queued write-entry layout and small helpers.
`ifndef DATA_ROW_WIDTH
`define DATA_ROW_WIDTH 96
`endif
`ifndef DATA_ADDRESS_WIDTH
`define DATA_ADDRESS_WIDTH 16
`endif
`ifndef X_RNG
`define X_RNG 95:64
`endif
`ifndef Y_RNG
`define Y_RNG 63:32
`endif
`ifndef Z_RNG
`define Z_RNG 31:0
`endif

package rf_writeback_arbiter_pkg;

   localparam int unsigned DATA_WIDTH = `DATA_ROW_WIDTH;
   localparam int unsigned ADDR_WIDTH = `DATA_ADDRESS_WIDTH;
   localparam int unsigned CH_WIDTH   = DATA_WIDTH / 3;

   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   // One queued write: {X,Y,Z} enables, resolved address, data row.
   typedef struct packed {
      logic [2:0]            mask;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wb_entry_t;

   localparam int unsigned ENTRY_WIDTH = $bits(wb_entry_t);

   // Frame-relative addresses wrap modulo 2^ADDR_WIDTH.
   function automatic logic [ADDR_WIDTH-1:0] resolve_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                          input logic                  relative,
                                                          input logic [ADDR_WIDTH-1:0] offset);
      return relative ? addr + offset : addr;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] pack_row(input logic [CH_WIDTH-1:0] x,
                                                      input logic [CH_WIDTH-1:0] y,
                                                      input logic [CH_WIDTH-1:0] z);
      logic [DATA_WIDTH-1:0] r;
      r         = '0;
      r[`X_RNG] = x;
      r[`Y_RNG] = y;
      r[`Z_RNG] = z;
      return r;
   endfunction

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Bundle of producer handshakes, frame offset, operand-fetch addresses and the
// register-file write port seen by the write-back stage.
interface rf_writeback_arbiter_if;
   import rf_writeback_arbiter_pkg::*;

   logic                  alu_valid;
   logic                  alu_ready;
   logic [ADDR_WIDTH-1:0] alu_address;
   logic                  alu_relative;
   logic [2:0]            alu_write_mask;
   logic [DATA_WIDTH-1:0] alu_data;

   logic                  mem_valid;
   logic                  mem_ready;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_relative;
   logic [2:0]            mem_write_mask;
   logic [DATA_WIDTH-1:0] mem_data;

   logic [ADDR_WIDTH-1:0] frame_offset;
   logic [ADDR_WIDTH-1:0] read_address0;
   logic [ADDR_WIDTH-1:0] read_address1;

   logic [2:0]            write_enable;
   logic [ADDR_WIDTH-1:0] write_address;
   logic [DATA_WIDTH-1:0] data;
   logic [2:0]            bypass_hit0;
   logic [2:0]            bypass_hit1;
   logic                  busy;

   modport master (
      output alu_valid, alu_address, alu_relative, alu_write_mask, alu_data,
      output mem_valid, mem_address, mem_relative, mem_write_mask, mem_data,
      output frame_offset, read_address0, read_address1,
      input  alu_ready, mem_ready, write_enable, write_address, data,
      input  bypass_hit0, bypass_hit1, busy
   );

   modport slave (
      input  alu_valid, alu_address, alu_relative, alu_write_mask, alu_data,
      input  mem_valid, mem_address, mem_relative, mem_write_mask, mem_data,
      input  frame_offset, read_address0, read_address1,
      output alu_ready, mem_ready, write_enable, write_address, data,
      output bypass_hit0, bypass_hit1, busy
   );

endinterface

// File: rtl/rf_wb_fifo2.sv
// Two-entry FIFO with full/empty flags. Push is ignored when full and pop is
// ignored when empty; simultaneous push and pop leave the count unchanged.
module rf_wb_fifo2 #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   logic [Width-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == 2'd2);
   assign empty   = (count_q == 2'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Write-back stage in front of the register-file write port. Two producers (ALU,
// MEM) each feed a 2-entry FIFO; one head per cycle is granted round-robin and
// registered onto the write port. Relative addresses are resolved at acceptance.
// Optional feature: define RF_WRITEBACK_BYPASS_EN to enable the operand-fetch
// bypass comparators; otherwise bypass_hit0/1 are tied to zero.
module rf_writeback_arbiter (
   input logic                  clk,
   input logic                  rst_n,
   rf_writeback_arbiter_if.slave bus
);
   import rf_writeback_arbiter_pkg::*;

   wb_entry_t             alu_in;
   wb_entry_t             mem_in;
   wb_entry_t             alu_head;
   wb_entry_t             mem_head;
   wb_entry_t             win;
   logic                  alu_full, alu_empty, mem_full, mem_empty;
   logic                  alu_push, mem_push;
   logic                  grant_alu, grant_mem, grant;
   logic                  last_q;
   logic [2:0]            we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;

   // Ready is forced low during reset; it never looks at a same-cycle pop.
   assign bus.alu_ready = rst_n & ~alu_full;
   assign bus.mem_ready = rst_n & ~mem_full;
   assign alu_push      = bus.alu_valid & bus.alu_ready;
   assign mem_push      = bus.mem_valid & bus.mem_ready;

   // Build the entries to queue, with the frame offset sampled now.
   always_comb begin
      alu_in      = '0;
      alu_in.mask = bus.alu_write_mask;
      alu_in.addr = resolve_addr(bus.alu_address, bus.alu_relative, bus.frame_offset);
      alu_in.data = bus.alu_data;
      mem_in      = '0;
      mem_in.mask = bus.mem_write_mask;
      mem_in.addr = resolve_addr(bus.mem_address, bus.mem_relative, bus.frame_offset);
      mem_in.data = bus.mem_data;
   end

   rf_wb_fifo2 #(
      .Width (ENTRY_WIDTH)
   ) u_alu_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (alu_push),
      .wdata (alu_in),
      .pop   (grant_alu),
      .rdata (alu_head),
      .full  (alu_full),
      .empty (alu_empty)
   );

   rf_wb_fifo2 #(
      .Width (ENTRY_WIDTH)
   ) u_mem_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (mem_push),
      .wdata (mem_in),
      .pop   (grant_mem),
      .rdata (mem_head),
      .full  (mem_full),
      .empty (mem_empty)
   );

   // Round-robin: a lone head wins; on contention the source not granted last wins.
   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      if (!alu_empty && (mem_empty || last_q == SRC_MEM)) begin
         grant_alu = 1'b1;
      end else if (!mem_empty) begin
         grant_mem = 1'b1;
      end
   end

   assign grant = grant_alu | grant_mem;
   assign win   = grant_alu ? alu_head : mem_head;

   // Output register and last-grant pointer; a zero-mask entry issues as no write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 3'b000;
         addr_q <= '0;
         data_q <= '0;
         last_q <= SRC_MEM;
      end else if (grant) begin
         we_q   <= win.mask;
         addr_q <= win.addr;
         data_q <= win.data;
         last_q <= grant_mem ? SRC_MEM : SRC_ALU;
      end else begin
         we_q <= 3'b000;
      end
   end

   assign bus.write_enable  = we_q;
   assign bus.write_address = addr_q;
   assign bus.data          = data_q;
   assign bus.busy          = ~alu_empty | ~mem_empty | (we_q != 3'b000);

`ifdef RF_WRITEBACK_BYPASS_EN
   assign bus.bypass_hit0 = we_q & {3{addr_q == bus.read_address0}};
   assign bus.bypass_hit1 = we_q & {3{addr_q == bus.read_address1}};
`else
   logic unused_read_addr;
   assign unused_read_addr = ^{bus.read_address0, bus.read_address1};
   assign bus.bypass_hit0  = 3'b000;
   assign bus.bypass_hit1  = 3'b000;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench for rf_writeback_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every write presented to the register file.
module tb_rf_writeback_arbiter;
   import rf_writeback_arbiter_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   wb_entry_t exp_q[$];

`ifdef RF_WRITEBACK_BYPASS_EN
   localparam logic [2:0] EXP_HIT = 3'b010;
`else
   localparam logic [2:0] EXP_HIT = 3'b000;
`endif

   rf_writeback_arbiter_if bus ();

   rf_writeback_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic wb_entry_t ent(input logic [2:0] m, input logic [ADDR_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] d);
      wb_entry_t e;
      e.mask = m;
      e.addr = a;
      e.data = d;
      return e;
   endfunction

   // Monitor: every write presented must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n && bus.write_enable != 3'b000) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got we=%b addr=%h, required no write",
                     bus.write_enable, bus.write_address);
         end else begin
            wb_entry_t e;
            e = exp_q.pop_front();
            if (bus.write_enable !== e.mask || bus.write_address !== e.addr ||
                bus.data !== e.data) begin
               n_fail++;
               $display("FAIL write: got we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                        bus.write_enable, bus.write_address, bus.data, e.mask, e.addr, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [ADDR_WIDTH-1:0] a, input logic rel,
                          input logic [2:0] m, input logic [DATA_WIDTH-1:0] d);
      bus.alu_valid      = v;
      bus.alu_address    = a;
      bus.alu_relative   = rel;
      bus.alu_write_mask = m;
      bus.alu_data       = d;
   endtask

   task automatic set_mem(input logic v, input logic [ADDR_WIDTH-1:0] a, input logic rel,
                          input logic [2:0] m, input logic [DATA_WIDTH-1:0] d);
      bus.mem_valid      = v;
      bus.mem_address    = a;
      bus.mem_relative   = rel;
      bus.mem_write_mask = m;
      bus.mem_data       = d;
   endtask

   // Hold an item valid until the source sees ready at a clock edge.
   task automatic send(input logic is_mem, input logic [ADDR_WIDTH-1:0] a,
                       input logic [DATA_WIDTH-1:0] d);
      logic r;
      logic ok;
      ok = 1'b0;
      if (is_mem) set_mem(1'b1, a, 1'b0, 3'b111, d);
      else        set_alu(1'b1, a, 1'b0, 3'b111, d);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         r = is_mem ? bus.mem_ready : bus.alu_ready;
         tick();
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      chk(is_mem ? "mem_send_accepted" : "alu_send_accepted", ok, 1'b1);
   endtask

   task automatic drain(input string name);
      logic done;
      done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.busy) begin
            done = 1'b1;
            break;
         end
      end
      chk({name, "_drained"}, done, 1'b1);
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_alu_ready"}, bus.alu_ready, 1'b0);
      chk({p, "_mem_ready"}, bus.mem_ready, 1'b0);
      chk({p, "_we"}, bus.write_enable, 3'b000);
      chk({p, "_addr"}, bus.write_address, '0);
      chk({p, "_data"}, bus.data, '0);
      chk({p, "_busy"}, bus.busy, 1'b0);
      chk({p, "_hit0"}, bus.bypass_hit0, 3'b000);
      chk({p, "_hit1"}, bus.bypass_hit1, 3'b000);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("rst_pulse");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      set_alu(1'b0, '0, 1'b0, 3'b000, '0);
      set_mem(1'b0, '0, 1'b0, 3'b000, '0);
      bus.frame_offset  = '0;
      bus.read_address0 = '0;
      bus.read_address1 = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #2 chk_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset_alu", bus.alu_ready, 1'b1);
      chk("ready_after_reset_mem", bus.mem_ready, 1'b1);

      // Single ALU write and its latency
      set_alu(1'b1, 16'h0010, 1'b0, 3'b111, pack_row(32'd1, 32'd2, 32'd3));
      exp_q.push_back(ent(3'b111, 16'h0010, pack_row(32'd1, 32'd2, 32'd3)));
      tick();
      set_alu(1'b0, '0, 1'b0, 3'b000, '0);
      @(negedge clk);
      chk("lat_we_not_yet", bus.write_enable, 3'b000);
      chk("lat_busy_queued", bus.busy, 1'b1);
      tick();
      @(negedge clk);
      chk("lat_we_issue", bus.write_enable, 3'b111);
      chk("lat_addr_issue", bus.write_address, 16'h0010);
      tick();
      @(negedge clk);
      chk("lat_we_done", bus.write_enable, 3'b000);
      chk("lat_addr_holds", bus.write_address, 16'h0010);
      chk("lat_busy_done", bus.busy, 1'b0);

      // Continuous contention from reset: ALU first, then strict alternation
      do_reset();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(ent(3'b111, 16'h0100 + 16'(i), pack_row(32'hA0 + i, 32'h0, 32'h0)));
         exp_q.push_back(ent(3'b111, 16'h0180 + 16'(i), pack_row(32'hB0 + i, 32'h0, 32'h0)));
      end
      fork
         begin
            for (int i = 0; i < 4; i++) send(1'b0, 16'h0100 + 16'(i), pack_row(32'hA0 + i, 32'h0, 32'h0));
            set_alu(1'b0, '0, 1'b0, 3'b000, '0);
         end
         begin
            for (int i = 0; i < 4; i++) send(1'b1, 16'h0180 + 16'(i), pack_row(32'hB0 + i, 32'h0, 32'h0));
            set_mem(1'b0, '0, 1'b0, 3'b000, '0);
         end
      join
      drain("contention");

      // Full-FIFO ready behaviour with the pointer favouring ALU
      set_alu(1'b1, 16'h0200, 1'b0, 3'b111, pack_row(32'hC0, 32'h0, 32'h0));
      set_mem(1'b1, 16'h0300, 1'b0, 3'b111, pack_row(32'hD0, 32'h0, 32'h0));
      exp_q.push_back(ent(3'b111, 16'h0200, pack_row(32'hC0, 32'h0, 32'h0)));
      exp_q.push_back(ent(3'b111, 16'h0300, pack_row(32'hD0, 32'h0, 32'h0)));
      exp_q.push_back(ent(3'b111, 16'h0201, pack_row(32'hC1, 32'h0, 32'h0)));
      exp_q.push_back(ent(3'b111, 16'h0301, pack_row(32'hD1, 32'h0, 32'h0)));
      exp_q.push_back(ent(3'b111, 16'h0202, pack_row(32'hC2, 32'h0, 32'h0)));
      exp_q.push_back(ent(3'b111, 16'h0302, pack_row(32'hD2, 32'h0, 32'h0)));
      tick();
      set_alu(1'b1, 16'h0201, 1'b0, 3'b111, pack_row(32'hC1, 32'h0, 32'h0));
      set_mem(1'b1, 16'h0301, 1'b0, 3'b111, pack_row(32'hD1, 32'h0, 32'h0));
      tick();
      @(negedge clk);
      chk("mem_ready_full", bus.mem_ready, 1'b0);
      set_alu(1'b1, 16'h0202, 1'b0, 3'b111, pack_row(32'hC2, 32'h0, 32'h0));
      set_mem(1'b1, 16'h0302, 1'b0, 3'b111, pack_row(32'hD2, 32'h0, 32'h0));
      tick();
      @(negedge clk);
      chk("mem_ready_after_pop", bus.mem_ready, 1'b1);
      chk("alu_ready_full", bus.alu_ready, 1'b0);
      set_alu(1'b0, '0, 1'b0, 3'b000, '0);
      tick();
      @(negedge clk);
      chk("alu_ready_after_pop", bus.alu_ready, 1'b1);
      set_mem(1'b0, '0, 1'b0, 3'b000, '0);
      drain("full_ready");

      // Address resolution
      bus.frame_offset = 16'h0100;
      set_alu(1'b1, 16'h0005, 1'b1, 3'b001, pack_row(32'h0, 32'h0, 32'h55));
      exp_q.push_back(ent(3'b001, 16'h0105, pack_row(32'h0, 32'h0, 32'h55)));
      tick();
      bus.frame_offset = 16'h0200;
      set_alu(1'b0, '0, 1'b0, 3'b000, '0);
      drain("rel_alu");
      bus.frame_offset = 16'h0002;
      set_alu(1'b1, 16'hFFFF, 1'b1, 3'b100, pack_row(32'h66, 32'h0, 32'h0));
      exp_q.push_back(ent(3'b100, 16'h0001, pack_row(32'h66, 32'h0, 32'h0)));
      tick();
      set_alu(1'b0, '0, 1'b0, 3'b000, '0);
      drain("rel_wrap");
      bus.frame_offset = 16'h0200;
      set_mem(1'b1, 16'h0010, 1'b1, 3'b011, pack_row(32'h0, 32'h77, 32'h78));
      exp_q.push_back(ent(3'b011, 16'h0210, pack_row(32'h0, 32'h77, 32'h78)));
      tick();
      set_mem(1'b0, '0, 1'b0, 3'b000, '0);
      drain("rel_mem");
      set_alu(1'b1, 16'h0042, 1'b0, 3'b111, pack_row(32'h42, 32'h43, 32'h44));
      exp_q.push_back(ent(3'b111, 16'h0042, pack_row(32'h42, 32'h43, 32'h44)));
      tick();
      set_alu(1'b0, '0, 1'b0, 3'b000, '0);
      drain("abs_alu");

      // Zero-mask entry is dropped but still uses a grant slot; bypass compare
      set_alu(1'b1, 16'h0033, 1'b0, 3'b000, pack_row(32'h9, 32'h9, 32'h9));
      tick();
      set_alu(1'b1, 16'h0033, 1'b0, 3'b010, pack_row(32'h4, 32'h5, 32'h6));
      exp_q.push_back(ent(3'b010, 16'h0033, pack_row(32'h4, 32'h5, 32'h6)));
      tick();
      set_alu(1'b0, '0, 1'b0, 3'b000, '0);
      bus.read_address0 = 16'h0033;
      bus.read_address1 = 16'h0034;
      @(negedge clk);
      chk("mask0_we", bus.write_enable, 3'b000);
      chk("mask0_busy", bus.busy, 1'b1);
      chk("mask0_hit0", bus.bypass_hit0, 3'b000);
      tick();
      @(negedge clk);
      chk("mask010_we", bus.write_enable, 3'b010);
      chk("bypass_hit0", bus.bypass_hit0, EXP_HIT);
      chk("bypass_hit1", bus.bypass_hit1, 3'b000);
      drain("mask");

      // Reset with entries queued discards everything
      set_alu(1'b1, 16'h0400, 1'b0, 3'b111, pack_row(32'hE0, 32'h0, 32'h0));
      set_mem(1'b1, 16'h0500, 1'b0, 3'b111, pack_row(32'hF0, 32'h0, 32'h0));
      tick();
      set_alu(1'b1, 16'h0401, 1'b0, 3'b111, pack_row(32'hE1, 32'h0, 32'h0));
      set_mem(1'b1, 16'h0501, 1'b0, 3'b111, pack_row(32'hF1, 32'h0, 32'h0));
      tick();
      set_alu(1'b0, '0, 1'b0, 3'b000, '0);
      set_mem(1'b0, '0, 1'b0, 3'b000, '0);
      #1 rst_n = 1'b0;
      #1 chk_zero("mid_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_reset_busy", bus.busy, 1'b0);
      chk("post_reset_we", bus.write_enable, 3'b000);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Write-back stage directly upstream of the register file write port. Accepts results from two producers: the ALU/execute path and the memory/IO load path. Each producer is buffered in its own 2-entry FIFO. One write per cycle is granted round-robin, and the stage drives the register file's per-channel write enables, write address and 96-bit data row. Frame-relative addresses are resolved against the register file's frame offset output at acceptance time.

## Interface
- DATA_WIDTH, `DATA_ROW_WIDTH, data row (X,Y,Z channels, DATA_WIDTH/3 each)
- ADDR_WIDTH, `DATA_ADDRESS_WIDTH, register address width
- Clock  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- iAluValid / oAluReady  in/out  1  ALU result handshake
- iAluAddress  in  ADDR_WIDTH  destination register
- iAluRelative  in  1  1 = address is frame-relative
- iAluWriteMask  in  3  {X,Y,Z} channel enables
- iAluData  in  DATA_WIDTH  result row
- iMemValid, oMemReady, iMemAddress, iMemRelative, iMemWriteMask, iMemData  same shapes as ALU channel, load path
- iFrameOffset  in  ADDR_WIDTH  current frame offset from register file
- iReadAddress0, iReadAddress1  in  ADDR_WIDTH  operand fetch addresses (bypass compare)
- oWriteEnable  out  3  to register file iWriteEnable
- oWriteAddress  out  ADDR_WIDTH  to register file iWriteAddress
- oData  out  DATA_WIDTH  to register file iData
- oBypassHit0, oBypassHit1  out  3  per-channel match of the in-flight write against each read address
- oBusy  out  1  any FIFO entry or output write pending

## Operation
**Acceptance**
- A source transfer occurs on a rising edge with Valid & Ready.
- Ready = FIFO not full. Ready does not consider a same-cycle pop.
- The stored address is the resolved address: iAddress + iFrameOffset mod 2^ADDR_WIDTH if Relative, else iAddress. iFrameOffset is sampled at acceptance.

**Arbitration and issue**
- Arbitration runs each cycle on the FIFO heads.
- Only one head non-empty → grant it.
- Both non-empty → grant the source not granted last.
- The last-grant pointer updates on every grant.
- The granted head is popped. Its mask, address and data load the output register on the same edge.
- A cycle with no grant loads oWriteEnable=0. Address and data hold their previous values.
- An entry with mask 3'b000 is popped and consumes a grant slot. It produces oWriteEnable=0, i.e. it is dropped.
- FIFO ordering is preserved per source. No ordering is guaranteed across sources.

**Status and bypass**
- oBusy = either FIFO non-empty OR oWriteEnable≠0.
- oBypassHitN = oWriteEnable & {3{oWriteAddress==iReadAddressN}}. This is combinational.

## Timing
**Reset**
- Reset low: FIFOs empty, grant pointer = MEM, so ALU wins the first contention.
- All outputs 0 while Reset is low, including both Ready signals.
- Ready rises in the first cycle after deassertion.
- Reset asserted mid-operation discards all queued and in-flight writes immediately. No partial write is emitted.

**Latency**
- Transfer at edge T into an empty FIFO with no contention → oWriteEnable valid for exactly the cycle after edge T+1.
- The register file commits the write at edge T+2.

**Throughput**
- 1 write per cycle aggregate.
- Under continuous contention, each source gets alternate cycles.
- A single streaming source with no contention sustains 1/cycle. The FIFO never fills.

**Boundary cases**
- A full FIFO holds Ready low for the whole cycle, even if its head is granted that cycle. Ready rises the following cycle.
- Simultaneous push and pop on a non-full FIFO are both honoured.
- Count stays constant when push and pop coincide.
- Address wrap: 0xFFFF + offset 2 → 0x0001 at ADDR_WIDTH=16.

## Configuration
- RF_WRITEBACK_BYPASS_EN defined: oBypassHit0/1 are computed as above.
- Not defined: oBypassHit0/1 are tied to 0 and the address comparators are absent. Operand fetch then stalls on RAW hazards itself.
- Ports exist in both builds.

## Structure
- Shared package/definitions file:
  - source index constants (SRC_ALU=0, SRC_MEM=1)
  - write-entry field layout (mask, address, data), reusing existing `X_RNG/`Y_RNG/`Z_RNG
- One sub-module: rf_wb_fifo2, a parameterised 2-entry FIFO with full/empty flags and asynchronous active-low reset. It is instantiated twice.
- Arbiter, address resolution and output register are top-level logic.

## Test plan
- Reset release, single ALU write: addr 0x0010, mask 3'b111, data X=1,Y=2,Z=3 → oWriteEnable=3'b111, oWriteAddress=0x0010 one cycle after acceptance, otherwise 0.
- Both sources valid every cycle, 4 items each → grants alternate ALU, MEM, ALU, MEM… and each source's order is preserved.
- MEM Valid held while no grant is possible (ALU flood, pointer favouring ALU): after 2 accepted entries oMemReady=0, then returns to 1 the cycle after the first MEM pop.
- Relative write, iAluAddress=0x0005, iFrameOffset=0x0100 at acceptance, offset changes to 0x0200 next cycle → oWriteAddress=0x0105.
- Mask 3'b000 entry followed by mask 3'b010 entry → one cycle with oWriteEnable=0, then 3'b010. With RF_WRITEBACK_BYPASS_EN and iReadAddress0 equal to the write address, oBypassHit0=3'b010.
- Reset pulled low with 3 entries queued → all outputs 0 at once. After release oBusy=0 and no write is emitted.
